// File: rtl/pipe_decode_pkg.sv
// Shared Y86-64 ISA constants and the decode->execute pipeline register layout,
// imported by the fetch, decode, execute and memory stages.
package pipe_decode_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] RNONE   = 4'hF;
    localparam logic [3:0] RSP     = 4'h4;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] valc;
        logic [63:0] vala;
        logic [63:0] valb;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [3:0]  srca;
        logic [3:0]  srcb;
    } ereg_t;

endpackage

// File: rtl/pipe_decode_regfile.sv
// Architectural register file: two asynchronous read ports, two write ports
// committed on the rising edge, synchronous clear.
module pipe_regfile #(
    parameter logic [3:0] RNONE = 4'hF,
    parameter int          NREGS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  src_a,
    input  logic [3:0]  src_b,
    output logic [63:0] rdata_a,
    output logic [63:0] rdata_b,
    input  logic [3:0]  dst_e,
    input  logic [63:0] wdata_e,
    input  logic [3:0]  dst_m,
    input  logic [63:0] wdata_m
);

    logic [63:0] regs [NREGS];

    // Port M is written last so it wins when both ports target one register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            if (dst_e != RNONE && int'(dst_e) < NREGS) regs[dst_e] <= wdata_e;
            if (dst_m != RNONE && int'(dst_m) < NREGS) regs[dst_m] <= wdata_m;
        end
    end

    assign rdata_a = (int'(src_a) < NREGS) ? regs[src_a] : '0;
    assign rdata_b = (int'(src_b) < NREGS) ? regs[src_b] : '0;

endmodule

// File: rtl/pipe_decode.sv
// Y86-64 decode stage: register ID decode, operand forwarding and the E
// pipeline register with stall/bubble control.
module pipe_decode #(
    parameter logic [3:0] RNONE = 4'hF,
    parameter int          NREGS = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  D_icode,
    input  logic [3:0]  D_ifun,
    input  logic [3:0]  D_rA,
    input  logic [3:0]  D_rB,
    input  logic [63:0] D_valC,
    input  logic [63:0] D_valP,
    input  logic        E_stall,
    input  logic        E_bubble,
    input  logic [3:0]  e_dstE,
    input  logic [63:0] e_valE,
    input  logic [3:0]  M_dstM,
    input  logic [63:0] m_valM,
    input  logic [3:0]  M_dstE,
    input  logic [63:0] M_valE,
    input  logic [3:0]  W_dstM,
    input  logic [63:0] W_valM,
    input  logic [3:0]  W_dstE,
    input  logic [63:0] W_valE,
    output logic [3:0]  d_srcA,
    output logic [3:0]  d_srcB,
    output logic [3:0]  E_icode,
    output logic [3:0]  E_ifun,
    output logic [3:0]  E_dstE,
    output logic [3:0]  E_dstM,
    output logic [3:0]  E_srcA,
    output logic [3:0]  E_srcB,
    output logic [63:0] E_valC,
    output logic [63:0] E_valA,
    output logic [63:0] E_valB
);
    import pipe_decode_pkg::*;

    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic [63:0] rf_a, rf_b, val_a, val_b;
    ereg_t       e_q, e_d, nop;

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            IRRMOVQ: begin src_a = D_rA; dst_e = D_rB; end
            IIRMOVQ: dst_e = D_rB;
            IRMMOVQ: begin src_a = D_rA; src_b = D_rB; end
            IMRMOVQ: begin src_b = D_rB; dst_m = D_rA; end
            IOPQ:    begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
            ICALL:   begin src_b = RSP;  dst_e = RSP; end
            IRET:    begin src_a = RSP;  src_b = RSP; dst_e = RSP; end
            IPUSHQ:  begin src_a = D_rA; src_b = RSP; dst_e = RSP; end
            IPOPQ:   begin src_a = RSP;  src_b = RSP; dst_e = RSP; dst_m = D_rA; end
            default: ;
        endcase
    end

    pipe_regfile #(.RNONE(RNONE), .NREGS(NREGS)) u_rf (
        .clk     (clk),
        .rst     (rst),
        .src_a   (src_a),
        .src_b   (src_b),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .dst_e   (W_dstE),
        .wdata_e (W_valE),
        .dst_m   (W_dstM),
        .wdata_m (W_valM)
    );

    // Youngest producer wins; RNONE is filtered first so an idle stage never matches.
    function automatic logic [63:0] fwd(input logic [3:0] src, input logic [63:0] rf);
        if (src == RNONE)       return '0;
        else if (src == e_dstE) return e_valE;
        else if (src == M_dstM) return m_valM;
        else if (src == M_dstE) return M_valE;
        else if (src == W_dstM) return W_valM;
        else if (src == W_dstE) return W_valE;
        else                    return rf;
    endfunction

    always_comb begin
        val_a = fwd(src_a, rf_a);
        if (D_icode == IJXX || D_icode == ICALL) val_a = D_valP;
        val_b = fwd(src_b, rf_b);
    end

    always_comb begin
        nop       = '0;
        nop.icode = INOP;
        nop.dste  = RNONE;
        nop.dstm  = RNONE;
        nop.srca  = RNONE;
        nop.srcb  = RNONE;

        e_d       = '0;
        e_d.icode = D_icode;
        e_d.ifun  = D_ifun;
        e_d.valc  = D_valC;
        e_d.vala  = val_a;
        e_d.valb  = val_b;
        e_d.dste  = dst_e;
        e_d.dstm  = dst_m;
        e_d.srca  = src_a;
        e_d.srcb  = src_b;
    end

    always_ff @(posedge clk) begin
        if (rst)           e_q <= nop;
        else if (E_stall)  e_q <= e_q;
        else if (E_bubble) e_q <= nop;
        else               e_q <= e_d;
    end

    assign d_srcA  = src_a;
    assign d_srcB  = src_b;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.valc;
    assign E_valA  = e_q.vala;
    assign E_valB  = e_q.valb;
    assign E_dstE  = e_q.dste;
    assign E_dstM  = e_q.dstm;
    assign E_srcA  = e_q.srca;
    assign E_srcB  = e_q.srcb;

endmodule

// File: tb/tb_pipe_decode.sv
// Directed and randomized checks of pipe_decode against an instruction-level
// reference model of the decode stage and register file.
module tb_pipe_decode;

    logic        clk, rst;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic        E_stall, E_bubble;
    logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
    logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
    logic [3:0]  d_srcA, d_srcB, E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
    logic [63:0] E_valC, E_valA, E_valB;

    pipe_decode dut (
        .clk(clk), .rst(rst),
        .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
        .D_valC(D_valC), .D_valP(D_valP),
        .E_stall(E_stall), .E_bubble(E_bubble),
        .e_dstE(e_dstE), .e_valE(e_valE),
        .M_dstM(M_dstM), .m_valM(m_valM), .M_dstE(M_dstE), .M_valE(M_valE),
        .W_dstM(W_dstM), .W_valM(W_valM), .W_dstE(W_dstE), .W_valE(W_valE),
        .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_ifun(E_ifun), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .E_srcA(E_srcA), .E_srcB(E_srcB),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  icode, ifun, dste, dstm, srca, srcb;
        logic [63:0] valc, vala, valb;
    } ex_t;

    logic [63:0] m_regs [15];
    ex_t         m_e;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ex_t nop_ex();
        ex_t n;
        n.icode = 4'h1; n.ifun = 4'h0;
        n.dste = 4'hF; n.dstm = 4'hF; n.srca = 4'hF; n.srcb = 4'hF;
        n.valc = 64'd0; n.vala = 64'd0; n.valb = 64'd0;
        return n;
    endfunction

    function automatic logic [3:0] r_srca(input logic [3:0] ic, input logic [3:0] ra);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] r_srcb(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] r_dste(input logic [3:0] ic, input logic [3:0] rb);
        if (ic inside {4'h2, 4'h3, 4'h6}) return rb;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] r_dstm(input logic [3:0] ic, input logic [3:0] ra);
        return (ic inside {4'h5, 4'hB}) ? ra : 4'hF;
    endfunction

    function automatic logic [63:0] r_operand(input logic [3:0] src);
        logic [3:0]  d [5];
        logic [63:0] v [5];
        if (src == 4'hF) return 64'd0;
        d = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
        v = '{e_valE, m_valM, M_valE, W_valM, W_valE};
        for (int k = 0; k < 5; k++)
            if (d[k] == src) return v[k];
        return m_regs[src];
    endfunction

    // One clock: check decode IDs, predict E, let the edge happen, check E.
    task automatic cycle();
        ex_t nx;
        logic [3:0] sa, sb;
        #1;
        sa = r_srca(D_icode, D_rA);
        sb = r_srcb(D_icode, D_rB);
        chk("d_srcA", d_srcA, sa);
        chk("d_srcB", d_srcB, sb);
        if (rst) nx = nop_ex();
        else if (E_stall) nx = m_e;
        else if (E_bubble) nx = nop_ex();
        else begin
            nx.icode = D_icode; nx.ifun = D_ifun; nx.valc = D_valC;
            nx.srca = sa; nx.srcb = sb;
            nx.dste = r_dste(D_icode, D_rB);
            nx.dstm = r_dstm(D_icode, D_rA);
            nx.vala = (D_icode inside {4'h7, 4'h8}) ? D_valP : r_operand(sa);
            nx.valb = r_operand(sb);
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
        end else begin
            if (W_dstE != 4'hF) m_regs[W_dstE] = W_valE;
            if (W_dstM != 4'hF) m_regs[W_dstM] = W_valM;
        end
        m_e = nx;
        #1;
        chk("E_icode", E_icode, m_e.icode);
        chk("E_ifun",  E_ifun,  m_e.ifun);
        chk("E_valC",  E_valC,  m_e.valc);
        chk("E_valA",  E_valA,  m_e.vala);
        chk("E_valB",  E_valB,  m_e.valb);
        chk("E_dstE",  E_dstE,  m_e.dste);
        chk("E_dstM",  E_dstM,  m_e.dstm);
        chk("E_srcA",  E_srcA,  m_e.srca);
        chk("E_srcB",  E_srcB,  m_e.srcb);
    endtask

    task automatic quiet();
        rst = 0; E_stall = 0; E_bubble = 0;
        e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
        e_valE = 0; m_valM = 0; M_valE = 0; W_valM = 0; W_valE = 0;
    endtask

    task automatic set_d(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [63:0] vc, input logic [63:0] vp);
        D_icode = ic; D_ifun = 4'h0; D_rA = ra; D_rB = rb; D_valC = vc; D_valP = vp;
    endtask

    initial begin
        quiet();
        set_d(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);

        // reset, then every register reads back zero
        rst = 1; cycle(); rst = 0;
        chk("rst_icode", E_icode, 4'h1);
        chk("rst_dstE", E_dstE, 4'hF);
        chk("rst_dstM", E_dstM, 4'hF);
        for (int i = 0; i < 15; i++) begin
            set_d(4'h6, 4'(i), 4'(i), 64'd0, 64'd0);
            cycle();
            chk("rst_reg", E_valA, 64'd0);
        end

        // write-back then read through the register file
        set_d(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
        W_dstE = 4'd3; W_valE = 64'd100; cycle(); quiet();
        set_d(4'h2, 4'd3, 4'd5, 64'd0, 64'd0); cycle();
        chk("rrmov_valA", E_valA, 64'd100);
        chk("rrmov_dstE", E_dstE, 4'd5);

        // execute-stage forward beats memory-stage forward
        set_d(4'h6, 4'd2, 4'd1, 64'd0, 64'd0);
        e_dstE = 4'd2; e_valE = 64'd7; M_dstE = 4'd2; M_valE = 64'd9; cycle(); quiet();
        chk("fwd_prio", E_valA, 64'd7);

        // dual write to one register keeps the memory value
        set_d(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
        W_dstE = 4'd6; W_dstM = 4'd6; W_valE = 64'd1; W_valM = 64'd2; cycle(); quiet();
        set_d(4'h6, 4'd6, 4'd0, 64'd0, 64'd0); cycle();
        chk("dual_wr", E_valA, 64'd2);

        // call uses valP; stall holds it while pushq waits
        set_d(4'h8, 4'hF, 4'hF, 64'h1234, 64'h40); cycle();
        chk("call_valA", E_valA, 64'h40);
        chk("call_srcB", E_srcB, 4'd4);
        chk("call_dstE", E_dstE, 4'd4);
        set_d(4'hA, 4'd1, 4'hF, 64'd0, 64'd0); E_stall = 1; cycle();
        chk("stall_icode", E_icode, 4'h8);
        chk("stall_valA", E_valA, 64'h40);

        // bubble, then reset overriding stall
        E_stall = 0; E_bubble = 1;
        set_d(4'h5, 4'd3, 4'd2, 64'h8, 64'd0); cycle();
        chk("bub_icode", E_icode, 4'h1);
        chk("bub_dstM", E_dstM, 4'hF);
        E_bubble = 0; cycle();
        E_stall = 1; rst = 1; set_d(4'h8, 4'hF, 4'hF, 64'd0, 64'h99); cycle();
        chk("rst_stall", E_icode, 4'h1);
        quiet();

        // randomized traffic with dense register collisions
        for (int n = 0; n < 600; n++) begin
            D_icode = 4'($urandom_range(0, 11));
            D_ifun  = 4'($urandom_range(0, 15));
            D_rA    = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 6));
            D_rB    = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 6));
            D_valC  = {$urandom, $urandom};
            D_valP  = {$urandom, $urandom};
            e_dstE  = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom_range(0, 6));
            M_dstM  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 6)) : 4'hF;
            M_dstE  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 6)) : 4'hF;
            W_dstM  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            W_dstE  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
            e_valE  = {$urandom, $urandom};
            m_valM  = {$urandom, $urandom};
            M_valE  = {$urandom, $urandom};
            W_valM  = {$urandom, $urandom};
            W_valE  = {$urandom, $urandom};
            E_stall  = ($urandom_range(0, 9) == 0);
            E_bubble = ($urandom_range(0, 9) == 0);
            rst      = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_decode.md
PIPE_DECODE -- requirements
Module: pipe_decode

Interface
REQ-001 SHALL have parameter RNONE, default 4'hF, meaning "no register" ID.
REQ-002 SHALL have parameter NREGS, default 15, meaning architectural registers %rax..%r14.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 D_icode/D_ifun  in  4/4  instruction code/function from D register.
REQ-006 D_rA/D_rB  in  4/4  register specifiers.
REQ-007 D_valC/D_valP  in  64/64  constant and next-PC.
REQ-008 E_stall/E_bubble  in  1/1  E-register hold / inject nop.
REQ-009 e_dstE/e_valE  in  4/64  execute-stage forwarding source.
REQ-010 M_dstM/m_valM, M_dstE/M_valE  in  4/64 each  memory-stage forwarding sources.
REQ-011 W_dstM/W_valM, W_dstE/W_valE  in  4/64 each  write-back port and forwarding sources.
REQ-012 d_srcA/d_srcB  out  4/4  combinational source IDs for the hazard unit.
REQ-013 E_icode/E_ifun/E_dstE/E_dstM/E_srcA/E_srcB  out  4 each  registered E fields.
REQ-014 E_valC/E_valA/E_valB  out  64 each  registered E operands.

Function
REQ-015 srcA SHALL be rA for icode 2,4,6,A; 4 (%rsp) for 9,B; else RNONE.
REQ-016 srcB SHALL be rB for icode 4,5,6; 4 for 8,9,A,B; else RNONE.
REQ-017 dstE SHALL be rB for icode 2,3,6; 4 for 8,9,A,B; else RNONE.
REQ-018 dstM SHALL be rA for icode 5,B; else RNONE.
REQ-019 Register file SHALL be NREGS x 64b; W_valE written to W_dstE and W_valM to W_dstM on rising edge when dst != RNONE.
REQ-020 When W_dstE == W_dstM != RNONE, W_valM SHALL be stored.
REQ-021 valA SHALL be D_valP for icode 7,8; else the first match of srcA against e_dstE, M_dstM, M_dstE, W_dstM, W_dstE (values e_valE, m_valM, M_valE, W_valM, W_valE); else register file read.
REQ-022 valB SHALL use the same priority chain for srcB, without the valP case.
REQ-023 srcX == RNONE SHALL never match a forwarding source; operand SHALL be 0.
REQ-024 Register file read SHALL be asynchronous and SHALL return the pre-edge value (forwarding covers same-cycle write-back).
REQ-025 E register SHALL load {icode, ifun, valC, valA, valB, dstE, dstM, srcA, srcB} each rising edge when not stalled and not bubbled.
REQ-026 E_stall=1 SHALL hold all E outputs unchanged; stall SHALL take priority over bubble.
REQ-027 E_bubble=1 (no stall) SHALL load nop: icode 1, ifun 0, all IDs RNONE, values 0.
REQ-028 Latency: D inputs SHALL appear on E outputs one cycle later.

Reset
REQ-029 rst SHALL take priority over stall and bubble.
REQ-030 rst SHALL load the nop bubble into the E register (REQ-027 values).
REQ-031 rst SHALL clear all NREGS registers to 0.
REQ-032 rst asserted mid-stream SHALL discard any pending write-back in that cycle.

Structure
REQ-033 Icode constants (HALT..POPQ), RNONE and RSP=4 SHALL live in the shared y86 package used by fetch/execute/memory.
REQ-034 Register file SHALL be a sub-module, pipe_regfile (two async read ports, two sync write ports, sync reset).

Verification
REQ-035 rst 1 cycle -> E_icode=1, E_dstE=E_dstM=F, all regs read 0.
REQ-036 W_dstE=3, W_valE=100; next cycle D rrmovq rA=3 rB=5 -> E_valA=100, E_dstE=5.
REQ-037 D opq rA=2; e_dstE=2/e_valE=7, M_dstE=2/M_valE=9 -> E_valA=7 (execute wins).
REQ-038 W_dstE=W_dstM=6, W_valE=1, W_valM=2 -> reg 6 later reads 2.
REQ-039 D call valP=0x40 -> E_valA=0x40, E_srcB=4, E_dstE=4; pushq with E_stall=1 -> E outputs unchanged.
REQ-040 E_bubble=1 with D mrmovq -> E_icode=1, E_dstM=F; rst with E_stall=1 -> nop loaded.
